// File: rtl/fetch_queue.sv
// Instruction fetch unit: sequential PC, QDEPTH-entry instruction queue, redirect and range-fault handling.
// Optional zero-latency head bypass enabled by defining FETCH_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic        fault
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL  = CW'(QDEPTH);
  localparam logic [16:0]   LIMIT = 17'(IMEM_BYTES);

  typedef enum logic {RUN, FAULT} state_t;

  state_t        state;
  logic [15:0]   pc;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [15:0]   q_instr [QDEPTH];
  logic [15:0]   q_pc    [QDEPTH];

  logic in_range;
  logic can_fetch;
  logic q_valid;
  logic q_deq;
  logic byp_take;
  logic enq;
  logic wr;

  assign imem_addr = pc;
  // 17-bit sum so a PC near 16'hFFFF cannot wrap back into range.
  assign in_range  = ({1'b0, pc} + 17'd3) < LIMIT;
  assign can_fetch = (state == RUN) & ~redirect & in_range;
  assign q_valid   = (count != '0) & ~redirect;
  assign q_deq     = q_valid & out_ready;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = can_fetch & (count == '0);
  assign out_valid = q_valid | bypass;
  assign out_instr = bypass ? imem_instr : q_instr[head];
  assign out_pc    = bypass ? pc : q_pc[head];
  assign byp_take  = bypass & out_ready;
`else
  assign out_valid = q_valid;
  assign out_instr = q_instr[head];
  assign out_pc    = q_pc[head];
  assign byp_take  = 1'b0;
`endif

  // A bypassed instruction advances the PC but never occupies a queue slot.
  assign enq = can_fetch & ((count < FULL) | q_deq);
  assign wr  = enq & ~byp_take;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc    <= RESET_PC;
      count <= '0;
      head  <= '0;
      tail  <= '0;
      state <= RUN;
      fault <= 1'b0;
    end else if (redirect) begin
      pc    <= {redirect_pc[15:2], 2'b00};
      count <= '0;
      head  <= '0;
      tail  <= '0;
      state <= RUN;
      fault <= fault | (redirect_pc[1:0] != 2'b00);
    end else begin
      if (state == RUN && !in_range) begin
        state <= FAULT;
        fault <= 1'b1;
      end
      if (enq) pc <= pc + 16'd4;
      if (wr) tail <= tail + 1'b1;
      if (q_deq) head <= head + 1'b1;
      unique case ({wr, q_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !redirect && wr) begin
      q_instr[tail] <= imem_instr;
      q_pc[tail]    <= pc;
    end
  end

endmodule
